// File: rtl/serial_sequence_generator.sv
// Parallel-to-serial frame generator with valid/ready load, per-bit strobe, done pulse and frame counter.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit after the data bits of every frame.
module serial_sequence_generator #(
    parameter int   WIDTH      = 8,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_LEVEL = 1'b0,
    parameter int   MSB_FIRST  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [7:0]       frame_count
);

`ifdef SEQ_GEN_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_BITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]            state_reg;
    logic [FRAME_BITS-1:0] shifter_reg;
    logic [CNT_W-1:0]      bit_cnt_reg;
    logic [3:0]            gap_cnt_reg;
    logic                  x_reg;
    logic                  x_valid_reg;
    logic                  done_reg;
    logic [7:0]            frame_count_reg;

    logic [FRAME_BITS-1:0] frame_word;
    logic                  accept;
    logic                  last_bit;

    // Reorder the word so the first bit to send always sits at the top; shifting is then always left.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_order
            if (MSB_FIRST != 0) begin : g_msb
                assign frame_word[FRAME_BITS-1-gi] = load_data[WIDTH-1-gi];
            end else begin : g_lsb
                assign frame_word[FRAME_BITS-1-gi] = load_data[gi];
            end
        end
    endgenerate

`ifdef SEQ_GEN_PARITY_EN
    assign frame_word[0] = ^load_data;
`endif

    assign last_bit = (state_reg == ST_SHIFT) && (bit_cnt_reg == '0);

    // With no gap the last-bit cycle also accepts, giving bubble-free streaming.
    assign load_ready = (state_reg == ST_IDLE) || ((GAP_CYCLES == 0) && last_bit);
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            shifter_reg     <= '0;
            bit_cnt_reg     <= '0;
            gap_cnt_reg     <= '0;
            x_reg           <= IDLE_LEVEL;
            x_valid_reg     <= 1'b0;
            done_reg        <= 1'b0;
            frame_count_reg <= 8'd0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                state_reg   <= ST_SHIFT;
                x_reg       <= frame_word[FRAME_BITS-1];
                x_valid_reg <= 1'b1;
                shifter_reg <= {frame_word[FRAME_BITS-2:0], 1'b0};
                bit_cnt_reg <= CNT_W'(FRAME_BITS - 1);
            end else begin
                case (state_reg)
                    ST_SHIFT: begin
                        if (bit_cnt_reg != '0) begin
                            x_reg       <= shifter_reg[FRAME_BITS-1];
                            shifter_reg <= shifter_reg << 1;
                            bit_cnt_reg <= bit_cnt_reg - CNT_W'(1);
                            // Count and flag the frame as its final bit goes onto x.
                            if (bit_cnt_reg == CNT_W'(1)) begin
                                done_reg        <= 1'b1;
                                frame_count_reg <= frame_count_reg + 8'd1;
                            end
                        end else begin
                            x_reg       <= IDLE_LEVEL;
                            x_valid_reg <= 1'b0;
                            if (GAP_CYCLES > 0) begin
                                state_reg   <= ST_GAP;
                                gap_cnt_reg <= 4'(GAP_CYCLES - 1);
                            end else begin
                                state_reg <= ST_IDLE;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt_reg == 4'd0) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg - 4'd1;
                        end
                    end
                    ST_IDLE: begin
                        x_reg       <= IDLE_LEVEL;
                        x_valid_reg <= 1'b0;
                    end
                    default: begin
                        state_reg   <= ST_IDLE;
                        x_reg       <= IDLE_LEVEL;
                        x_valid_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign x           = x_reg;
    assign x_valid     = x_valid_reg;
    assign done        = done_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_serial_sequence_generator.sv
// Directed bench: GAP_CYCLES=2 instance for framing/reset/ignore tests, GAP_CYCLES=0 instance for streaming.
module tb_serial_sequence_generator;

`ifdef SEQ_GEN_PARITY_EN
    localparam int FB = 9;
`else
    localparam int FB = 8;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] load_data;
    logic       load_valid;
    logic       load_ready, x, x_valid, busy, done;
    logic [7:0] frame_count;

    logic [7:0] d0_load_data;
    logic       d0_load_valid;
    logic       d0_load_ready, d0_x, d0_x_valid, d0_busy, d0_done;
    logic [7:0] d0_frame_count;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clock = ~clock;

    serial_sequence_generator #(.WIDTH(8), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0), .MSB_FIRST(1)) dut (
        .clock(clock), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .x(x), .x_valid(x_valid), .busy(busy), .done(done),
        .frame_count(frame_count)
    );

    serial_sequence_generator #(.WIDTH(8), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0), .MSB_FIRST(1)) dut0 (
        .clock(clock), .reset(reset), .load_data(d0_load_data), .load_valid(d0_load_valid),
        .load_ready(d0_load_ready), .x(d0_x), .x_valid(d0_x_valid), .busy(d0_busy), .done(d0_done),
        .frame_count(d0_frame_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Called at a negedge with the block idle; returns at the first negedge after the gap.
    task automatic send_frame(input string tag, input logic [7:0] word, input logic par, input int inject_at);
        logic exp_bit;
        load_data  = word;
        load_valid = 1'b1;
        @(negedge clock);
        load_valid = 1'b0;
        load_data  = ~word;
        for (int i = 0; i < FB; i++) begin
            if (i < 8) exp_bit = word[7-i];
            else       exp_bit = par;
            check({tag, " x"}, 32'(x), 32'(exp_bit));
            check({tag, " x_valid"}, 32'(x_valid), 32'd1);
            check({tag, " done"}, 32'(done), 32'(i == FB-1));
            check({tag, " busy"}, 32'(busy), 32'd1);
            if (i == inject_at) begin
                load_valid = 1'b1;
                load_data  = 8'h00;
            end else begin
                load_valid = 1'b0;
            end
            if (i != FB-1) @(negedge clock);
        end
        $display("frame %s word=%02h sent, frame_count=%0d", tag, word, frame_count);
        for (int g = 0; g < 2; g++) begin
            @(negedge clock);
            check({tag, " gap x_valid"}, 32'(x_valid), 32'd0);
            check({tag, " gap load_ready"}, 32'(load_ready), 32'd0);
            check({tag, " gap x"}, 32'(x), 32'd0);
        end
        @(negedge clock);
        check({tag, " post load_ready"}, 32'(load_ready), 32'd1);
        check({tag, " post busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] stream;
        logic        exp_bit;
        reset = 1'b1;
        load_data = 8'h00;  load_valid = 1'b0;
        d0_load_data = 8'h00; d0_load_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst x", 32'(x), 32'd0);
        check("rst load_ready", 32'(load_ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        reset = 1'b0;

        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check("idle x", 32'(x), 32'd0);
            check("idle x_valid", 32'(x_valid), 32'd0);
            check("idle load_ready", 32'(load_ready), 32'd1);
            check("idle frame_count", 32'(frame_count), 32'd0);
        end
        $display("idle 10 cycles after reset checked");

        // 1011_0010: four ones, even parity bit 0
        send_frame("b2", 8'hB2, 1'b0, -1);
        check("b2 frame_count", 32'(frame_count), 32'd1);

        // Streaming with no gap: A5 then 3C, both even parity 0
        stream = 16'hA53C;
        d0_load_data  = 8'hA5;
        d0_load_valid = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 2*FB; i++) begin
            if (i % FB == 8)   exp_bit = 1'b0;
            else if (i < FB)   exp_bit = stream[15-i];
            else               exp_bit = stream[7-(i-FB)];
            check("stream x", 32'(d0_x), 32'(exp_bit));
            check("stream x_valid", 32'(d0_x_valid), 32'd1);
            check("stream done", 32'(d0_done), 32'((i == FB-1) || (i == 2*FB-1)));
            if (i == 1)    check("stream mid load_ready", 32'(d0_load_ready), 32'd0);
            if (i == FB-1) check("stream last load_ready", 32'(d0_load_ready), 32'd1);
            if (i == 0)  d0_load_data  = 8'h3C;
            if (i == FB) d0_load_valid = 1'b0;
            @(negedge clock);
        end
        check("stream end x_valid", 32'(d0_x_valid), 32'd0);
        check("stream end busy", 32'(d0_busy), 32'd0);
        check("stream frame_count", 32'(d0_frame_count), 32'd2);
        $display("stream A5,3C done, frame_count=%0d", d0_frame_count);

        // Abort frame FF during its 4th bit
        load_data = 8'hFF; load_valid = 1'b1;
        @(negedge clock);
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abort x", 32'(x), 32'd1);
            @(negedge clock);
        end
        check("abort 4th x", 32'(x), 32'd1);
        reset = 1'b1;
        #1;
        check("abort async x", 32'(x), 32'd0);
        check("abort async x_valid", 32'(x_valid), 32'd0);
        check("abort async busy", 32'(busy), 32'd0);
        check("abort async done", 32'(done), 32'd0);
        check("abort async load_ready", 32'(load_ready), 32'd1);
        check("abort frame_count", 32'(frame_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("abort idle x_valid", 32'(x_valid), 32'd0);
        $display("reset mid-frame checked");

        // 1001_0110: parity 0
        send_frame("96", 8'h96, 1'b0, -1);
        check("96 frame_count", 32'(frame_count), 32'd1);

        // 1100_0011 with a load pulse of 00 during the 3rd bit
        send_frame("c3", 8'hC3, 1'b0, 2);
        check("c3 frame_count", 32'(frame_count), 32'd2);
        for (int c = 0; c < 12; c++) begin
            check("ignored x_valid", 32'(x_valid), 32'd0);
            @(negedge clock);
        end
        check("ignored frame_count", 32'(frame_count), 32'd2);
        $display("ignored load during shift checked");

        // 0000_0111: odd weight, parity 1; 0000_0011: parity 0
        send_frame("07", 8'h07, 1'b1, -1);
        check("07 frame_count", 32'(frame_count), 32'd3);
        send_frame("03", 8'h03, 1'b0, -1);
        check("03 frame_count", 32'(frame_count), 32'd4);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
